// File: rtl/alu_dispatch.sv
// Issue stage for the add/sub unit and the (WIDTH+1)-bit multiplier: one op in flight,
// uniform tagged result port with a timeout error flag.
module alu_dispatch #(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int ADD_LAT     = 1,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_add,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_cout,
  output logic             mul_in_valid,
  output logic [WIDTH:0]   mul_a,
  output logic [WIDTH:0]   mul_b,
  input  logic [WIDTH:0]   mul_out,
  input  logic             mul_out_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  localparam int CNT_MAX = (ADD_LAT > MUL_TIMEOUT) ? ADD_LAT : MUL_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ADD_DONE = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADD_WAIT, MUL_WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic               add_add_q, add_add_d, add_cin_q, add_cin_d;
  logic [WIDTH:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               mul_vld_q, mul_vld_d;
  logic [TAG_W-1:0]   tag_q, tag_d, res_tag_q, res_tag_d;
  logic [WIDTH:0]     res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic               accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_add_q  <= 1'b0;
      add_cin_q  <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_vld_q  <= 1'b0;
      tag_q      <= '0;
      res_tag_q  <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_add_q  <= add_add_d;
      add_cin_q  <= add_cin_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_vld_q  <= mul_vld_d;
      tag_q      <= tag_d;
      res_tag_q  <= res_tag_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = in_op[1] ? MUL_WAIT : ADD_WAIT;
      ADD_WAIT: if (cnt_q == ADD_DONE) state_d = HOLD;
      MUL_WAIT: if (mul_out_valid || cnt_q == MUL_LAST) state_d = HOLD;
      HOLD:     if (res_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next-state; mul_out_valid outside MUL_WAIT falls through untouched.
  always_comb begin
    cnt_d      = cnt_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_add_d  = add_add_q;
    add_cin_d  = add_cin_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_vld_d  = 1'b0;
    tag_d      = tag_q;
    res_tag_d  = res_tag_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: if (accept) begin
        tag_d = in_tag;
        cnt_d = '0;
        if (!in_op[1]) begin
          add_a_d   = in_a;
          add_b_d   = in_b;
          add_add_d = ~in_op[0];
          add_cin_d = in_cin;
        end else begin
          mul_a_d   = {(~in_op[0] & in_a[WIDTH-1]), in_a};
          mul_b_d   = {(~in_op[0] & in_b[WIDTH-1]), in_b};
          mul_vld_d = 1'b1;
        end
      end
      ADD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == ADD_DONE) begin
          res_data_d = {add_cout, add_out};
          res_err_d  = 1'b0;
          res_tag_d  = tag_q;
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_out_valid) begin
          res_data_d = mul_out;
          res_err_d  = 1'b0;
          res_tag_d  = tag_q;
        end else if (cnt_q == MUL_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          res_tag_d  = tag_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = rst && (state_q == IDLE);
    res_valid = (state_q == HOLD);
  end

  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_add      = add_add_q;
  assign add_cin      = add_cin_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_in_valid = mul_vld_q;
  assign res_data     = res_data_q;
  assign res_tag      = res_tag_q;
  assign res_err      = res_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a registered add/sub unit model and hand-driven multiplier returns.
module tb_alu_dispatch;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        in_cin;
  logic [3:0]  in_tag;
  logic [31:0] add_a, add_b, add_out;
  logic        add_add, add_cin, add_cout;
  logic        mul_in_valid, mul_out_valid;
  logic [32:0] mul_a, mul_b, mul_out;
  logic        res_valid, res_ready, res_err;
  logic [32:0] res_data;
  logic [3:0]  res_tag;

  int total = 0;
  int bad   = 0;

  alu_dispatch #(.WIDTH(32), .TAG_W(4), .ADD_LAT(1), .MUL_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_add(add_add), .add_cin(add_cin),
    .add_out(add_out), .add_cout(add_cout),
    .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_out_valid(mul_out_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // One-cycle add/sub unit: result is valid one cycle after its inputs settle.
  always @(posedge clk) begin
    if (add_add) {add_cout, add_out} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    else         {add_cout, add_out} <= {1'b0, add_a} + {1'b0, ~add_b} + {32'd0, add_cin};
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [3:0]  tag;
    logic [32:0] exp;
  } add_vec_t;

  add_vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] tag);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_cin = cin; in_tag = tag; in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_cin = ~cin; in_tag = ~tag;
    chk("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_after_consume", res_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  task automatic run_add(input add_vec_t v);
    int cyc;
    issue(v.op, v.a, v.b, v.cin, v.tag);
    chk("add_add", add_add, {63'd0, ~v.op[0]});
    chk("add_cin", add_cin, v.cin);
    chk("add_a", add_a, v.a);
    chk("add_b", add_b, v.b);
    wait_res(cyc);
    chk("add_latency", cyc, 2);
    chk("add_res_data", res_data, v.exp);
    chk("add_res_tag", res_tag, v.tag);
    chk("add_res_err", res_err, 0);
    consume();
  endtask

  initial begin
    int cyc;
    rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_tag = '0; mul_out = '0; mul_out_valid = 1'b0; res_ready = 1'b0;

    vecs[0] = '{op: 2'b00, a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, tag: 4'd3, exp: 33'h1_0000_0000};
    vecs[1] = '{op: 2'b01, a: 32'd5,         b: 32'd7,         cin: 1'b1, tag: 4'd9, exp: 33'h0_FFFF_FFFE};
    vecs[2] = '{op: 2'b00, a: 32'd1,         b: 32'd2,         cin: 1'b1, tag: 4'd1, exp: 33'h0_0000_0004};
    vecs[3] = '{op: 2'b01, a: 32'd0,         b: 32'd0,         cin: 1'b1, tag: 4'd12, exp: 33'h1_0000_0000};
    vecs[4] = '{op: 2'b00, a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, tag: 4'd15, exp: 33'h0_8000_0000};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_outputs", {add_a, add_b, add_add, add_cin, mul_in_valid, res_err, res_tag},
        64'd0);
    chk("rst_mul_res", {mul_a | mul_b | res_data}, 0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_add(vecs[i]);

    // Signed multiply, result returned on the 4th wait cycle
    issue(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, 4'd6);
    chk("smul_mul_a", mul_a, 33'h1_FFFF_FFFD);
    chk("smul_mul_b", mul_b, 33'h0_0000_0005);
    chk("smul_start_pulse", mul_in_valid, 1);
    @(negedge clk);
    chk("smul_start_drop", mul_in_valid, 0);
    repeat (2) @(negedge clk);
    mul_out = 33'h1_FFFF_FFF1; mul_out_valid = 1'b1;
    chk("smul_not_early", res_valid, 0);
    @(negedge clk);
    mul_out_valid = 1'b0; mul_out = '0;
    chk("smul_res_valid", res_valid, 1);
    chk("smul_res_data", res_data, 33'h1_FFFF_FFF1);
    chk("smul_res_err", res_err, 0);
    chk("smul_res_tag", res_tag, 4'd6);
    consume();

    // Unsigned multiply held under backpressure while a new request waits
    issue(2'b11, 32'h8000_0000, 32'd2, 1'b0, 4'd5);
    chk("umul_mul_a", mul_a, 33'h0_8000_0000);
    chk("umul_mul_b", mul_b, 33'h0_0000_0002);
    @(negedge clk);
    mul_out = 33'h1_0000_0000; mul_out_valid = 1'b1;
    @(negedge clk);
    mul_out_valid = 1'b0; mul_out = 33'h0_0BAD_0BAD;
    in_valid = 1'b1; in_op = 2'b00; in_tag = 4'd14;
    for (int k = 0; k < 5; k++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 33'h1_0000_0000);
      chk("bp_res_tag", res_tag, 4'd5);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();

    // Timeout, then a late multiplier return that must be ignored
    issue(2'b10, 32'd3, 32'd4, 1'b0, 4'd7);
    wait_res(cyc);
    chk("timeout_latency", cyc, 64);
    chk("timeout_err", res_err, 1);
    chk("timeout_data", res_data, 0);
    chk("timeout_tag", res_tag, 4'd7);
    consume();
    mul_out = 33'h0_0000_000C; mul_out_valid = 1'b1;
    @(negedge clk);
    mul_out_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("late_mul_res_valid", res_valid, 0);
      chk("late_mul_in_ready", in_ready, 1);
    end

    // Reset in MUL_WAIT abandons the op
    issue(2'b10, 32'd3, 32'd4, 1'b0, 4'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_outputs", {add_a, add_b, add_add, add_cin, mul_in_valid, res_err, res_tag},
        64'd0);
    chk("midrst_mul_res", {mul_a | mul_b | res_data}, 0);
    rst = 1'b1;
    #1;
    chk("midrst_release_ready", in_ready, 1);
    @(negedge clk);
    mul_out = 33'h0_0000_000C; mul_out_valid = 1'b1;
    @(negedge clk);
    mul_out_valid = 1'b0;
    @(negedge clk);
    chk("midrst_stray_res_valid", res_valid, 0);
    chk("midrst_stray_in_ready", in_ready, 1);
    run_add(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
